// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, active-low 7-segment glyphs and BCD decode for the BCD counter display
package bcd_pkg;
  localparam int NDIG_MAX = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: combinational single-digit BCD step with carry/borrow in and out
module bcd_digit (
  input  logic [3:0] d,
  input  logic       ci,
  input  logic       up,
  output logic [3:0] nxt,
  output logic       co
);
  assign co  = ci && (up ? d == 4'd9 : d == 4'd0);
  assign nxt = !ci ? d : co ? (up ? 4'd0 : 4'd9) : up ? d + 4'd1 : d - 4'd1;
endmodule

// File: rtl/bcd_counter_disp.sv
// bcd_counter_disp: N-digit BCD up/down counter with muxed 7-seg drive; LEADING_ZERO_BLANK_EN blanks leading zeros
module bcd_counter_disp
  import bcd_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                load,
  input  logic [4*NDIG-1:0]   load_val,
  input  logic                en,
  input  logic                up,
  output logic [4*NDIG-1:0]   bcd_out,
  output logic                carry,
  output logic                load_err,
  output logic [NDIG-1:0]     an,
  output logic [7:0]          seg
);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  logic [4*NDIG-1:0] nxt, san;
  logic [NDIG:0]     c;
  logic [NDIG-1:0]   bad;
  logic [3:0]        dig [NDIG];
  logic [SW-1:0]     scan;
  logic [IW-1:0]     idx;
  logic              tc;
  logic [7:0]        seg_nxt;
  assign c[0] = en;
  genvar k;
  generate
    for (k = 0; k < NDIG; k++) begin : g_dig
      bcd_digit u_dig (
        .d  (bcd_out[4*k+:4]),
        .ci (c[k]),
        .up (up),
        .nxt(nxt[4*k+:4]),
        .co (c[k+1])
      );
      assign bad[k]        = load_val[4*k+:4] > 4'd9;
      assign san[4*k+:4]   = bad[k] ? 4'd0 : load_val[4*k+:4];
      assign dig[k]        = bcd_out[4*k+:4];
    end
  endgenerate
  // With en low every ci is 0, so nxt already equals bcd_out and the count holds.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bcd_out  <= '0;
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      bcd_out  <= clr ? '0 : load ? san : nxt;
      carry    <= !clr && !load && c[NDIG];
      load_err <= !clr && load && |bad;
    end
`ifdef LEADING_ZERO_BLANK_EN
  logic [NDIG-1:0] lz;
  always_comb begin
    lz[NDIG-1] = dig[NDIG-1] == 4'd0;
    for (int i = NDIG - 2; i >= 0; i--) lz[i] = lz[i+1] && dig[i] == 4'd0;
  end
  assign seg_nxt = (idx != '0 && lz[idx]) ? SEG_BLANK : bcd_to_seg(dig[idx]);
`else
  assign seg_nxt = bcd_to_seg(dig[idx]);
`endif
  assign tc = scan == SW'(SCAN_DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      scan <= '0;
      idx  <= '0;
      an   <= '1;
      seg  <= SEG_BLANK;
    end else begin
      scan <= tc ? '0 : scan + 1'b1;
      idx  <= !tc ? idx : idx == IW'(NDIG - 1) ? '0 : idx + 1'b1;
      an   <= ~(NDIG'(1) << idx);
      seg  <= seg_nxt;
    end
endmodule

// File: tb/tb_bcd_counter_disp.sv
// tb_bcd_counter_disp: randomized self-checking bench against an arithmetic model of the counter and scan
module tb_bcd_counter_disp;
  logic        clk = 1'b0;
  logic        reset, clr, load, en, up;
  logic [15:0] load_val;
  logic [15:0] bcd_out;
  logic        carry, load_err;
  logic [3:0]  an;
  logic [7:0]  seg;
  int n_checks = 0;
  int n_fail = 0;
  int m_cnt, m_prev, t;
  bit m_carry, m_lerr;
  int p10[4] = '{1, 10, 100, 1000};
  logic [7:0] glyph[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  bcd_counter_disp #(.NDIG(4), .SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .bcd_out(bcd_out), .carry(carry), .load_err(load_err),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(int n);
    logic [15:0] r = '0;
    for (int k = 0; k < 4; k++) r[4*k+:4] = 4'((n / p10[k]) % 10);
    return r;
  endfunction

  function automatic logic [3:0] exp_an();
    if (t == 0) return 4'hF;
    return ~(4'b0001 << (((t - 1) / 4) % 4));
  endfunction

  function automatic logic [7:0] exp_seg();
    int i;
    if (t == 0) return 8'hFF;
    i = ((t - 1) / 4) % 4;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && m_prev / p10[i] == 0) return 8'hFF;
`endif
    return glyph[(m_prev / p10[i]) % 10];
  endfunction

  task automatic tick();
    int v;
    @(posedge clk);
    m_prev  = m_cnt;
    m_carry = 0;
    m_lerr  = 0;
    if (clr) m_cnt = 0;
    else if (load) begin
      m_cnt = 0;
      for (int k = 0; k < 4; k++) begin
        v = int'((load_val >> (4 * k)) & 16'hF);
        if (v > 9) begin
          m_lerr = 1;
          v = 0;
        end
        m_cnt += v * p10[k];
      end
    end else if (en) begin
      m_carry = up ? m_cnt == 9999 : m_cnt == 0;
      m_cnt   = up ? (m_cnt + 1) % 10000 : (m_cnt + 9999) % 10000;
    end
    t++;
    #1;
  endtask

  task automatic apply_reset(string tag);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (an !== 4'hF || seg !== 8'hFF || bcd_out !== 16'h0 || carry !== 1'b0 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s async reset: an=%h seg=%h bcd=%h carry=%b lerr=%b required an=f seg=ff bcd=0000 carry=0 lerr=0",
               tag, an, seg, bcd_out, carry, load_err);
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    m_cnt = 0; m_prev = 0; m_carry = 0; m_lerr = 0; t = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clr = 0; load = 0; en = 1; up = 1; load_val = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bcd_out !== 16'h0 || carry !== 0 || load_err !== 0 || an !== 4'hF || seg !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_state: bcd=%h carry=%b lerr=%b an=%h seg=%h required 0000 0 0 f ff",
               bcd_out, carry, load_err, an, seg);
    end
    reset = 1'b0;
    m_cnt = 0; m_prev = 0; t = 0;
  endtask

  task automatic test_count_up();
    en = 1; up = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (bcd_out !== to_bcd(m_cnt) || carry !== 1'b0 || m_cnt != i + 1) begin
        n_fail++;
        $display("FAIL count_up step %0d: bcd=%h carry=%b required bcd=%h carry=0", i, bcd_out, carry, to_bcd(i + 1));
      end
    end
    en = 0;
  endtask

  task automatic test_wrap_up();
    logic [15:0] want[4] = '{16'h9998, 16'h9999, 16'h0000, 16'h0001};
    load = 1; load_val = 16'h9998;
    tick();
    load = 0; en = 1; up = 1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bcd_out !== want[i] || carry !== (i == 2) || bcd_out !== to_bcd(m_cnt)) begin
        n_fail++;
        $display("FAIL wrap_up step %0d: bcd=%h carry=%b required bcd=%h carry=%b", i, bcd_out, carry, want[i], i == 2);
      end
      if (i < 3) tick();
    end
    en = 0;
  endtask

  task automatic test_wrap_down();
    logic [15:0] want[3] = '{16'h0001, 16'h0000, 16'h9999};
    load = 1; load_val = 16'h0001;
    tick();
    load = 0; en = 1; up = 0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bcd_out !== want[i] || carry !== (i == 2)) begin
        n_fail++;
        $display("FAIL wrap_down step %0d: bcd=%h carry=%b required bcd=%h carry=%b", i, bcd_out, carry, want[i], i == 2);
      end
      if (i < 2) tick();
    end
    en = 0;
    tick();
    n_checks++;
    if (bcd_out !== 16'h9999 || carry !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_down hold: bcd=%h carry=%b required bcd=9999 carry=0", bcd_out, carry);
    end
  endtask

  task automatic test_priority();
    clr = 1; load = 1; en = 1; up = 1; load_val = 16'h5555;
    tick();
    n_checks++;
    if (bcd_out !== 16'h0000 || carry !== 0 || load_err !== 0) begin
      n_fail++;
      $display("FAIL clr_priority: bcd=%h carry=%b lerr=%b required 0000 0 0", bcd_out, carry, load_err);
    end
    clr = 0; load_val = 16'h3456;
    tick();
    n_checks++;
    if (bcd_out !== 16'h3456 || carry !== 0) begin
      n_fail++;
      $display("FAIL load_over_en: bcd=%h carry=%b required 3456 0", bcd_out, carry);
    end
    load = 0; en = 0;
  endtask

  task automatic test_load_err();
    load = 1; load_val = 16'h12F4;
    tick();
    load = 0;
    n_checks++;
    if (bcd_out !== 16'h1204 || load_err !== 1'b1) begin
      n_fail++;
      $display("FAIL load_err pulse: bcd=%h lerr=%b required 1204 1", bcd_out, load_err);
    end
    tick();
    n_checks++;
    if (bcd_out !== 16'h1204 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_err clear: bcd=%h lerr=%b required 1204 0", bcd_out, load_err);
    end
  endtask

  task automatic test_scan();
    apply_reset("scan_start");
    load = 1; load_val = 16'h0042; en = 0;
    tick();
    load = 0;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (an !== exp_an() || seg !== exp_seg()) begin
        n_fail++;
        $display("FAIL scan cycle %0d: an=%h seg=%h required an=%h seg=%h", t, an, seg, exp_an(), exp_seg());
      end
      tick();
    end
    apply_reset("scan_mid");
    tick();
    n_checks++;
    if (an !== 4'hE || seg !== 8'hC0) begin
      n_fail++;
      $display("FAIL scan restart: an=%h seg=%h required an=e seg=c0", an, seg);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clr      = $urandom_range(0, 15) == 0;
      load     = $urandom_range(0, 7) == 0;
      en       = $urandom_range(0, 3) != 0;
      up       = $urandom_range(0, 1) == 1;
      load_val = 16'($urandom);
      if ($urandom_range(0, 9) == 0) load_val = $urandom_range(0, 1) ? 16'h9999 : 16'h0000;
      tick();
      n_checks++;
      if (bcd_out !== to_bcd(m_cnt) || carry !== m_carry || load_err !== m_lerr || an !== exp_an() || seg !== exp_seg()) begin
        n_fail++;
        $display("FAIL random cycle %0d: bcd=%h carry=%b lerr=%b an=%h seg=%h required bcd=%h carry=%b lerr=%b an=%h seg=%h",
                 i, bcd_out, carry, load_err, an, seg, to_bcd(m_cnt), m_carry, m_lerr, exp_an(), exp_seg());
      end
    end
    clr = 0; load = 0; en = 0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_priority();
    test_load_err();
    test_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
